// File: rtl/bnn_conv_pkg.sv
// Shared definitions for the binary 3x3 convolution engine.
//   - one-hot FSM state constants
//   - terminator header value and default popcount threshold
//   - bit positions of the fields inside a filter weight word
//   - width of the image-dimension field in an image header
//   - eff_thresh(): maps a raw 4-bit threshold to the threshold actually used
package bnn_conv_pkg;

  typedef logic [5:0] state_t;

  localparam state_t ST_IDLE   = 6'b000001;
  localparam state_t ST_LOAD_W = 6'b000010;
  localparam state_t ST_HDR    = 6'b000100;
  localparam state_t ST_FILL   = 6'b001000;
  localparam state_t ST_OUT    = 6'b010000;
  localparam state_t ST_DONE   = 6'b100000;

  localparam logic [15:0] TERMINATOR     = 16'h00FF;
  localparam logic [3:0]  DEFAULT_THRESH = 4'd5;

  localparam int WGT_LSB   = 0;
  localparam int WGT_MSB   = 8;
  localparam int THR_LSB   = 9;
  localparam int THR_MSB   = 12;
  localparam int WIN_BITS  = WGT_MSB - WGT_LSB + 1;
  localparam int HDR_DIM_W = 5;

  // A threshold of 0 or above the window size is meaningless; fall back to 5.
  function automatic logic [3:0] eff_thresh(input logic [3:0] t);
    return ((t == 4'd0) || (t > 4'd9)) ? DEFAULT_THRESH : t;
  endfunction

endpackage

// File: rtl/bnn_xnor_pe.sv
// One output-column processing element: XNOR the 3x3 window with the filter
// weights, count the matches and compare against the threshold.
//   weight  in  9  filter weights (bit i pairs with window bit i)
//   window  in  9  pixels: [2:0] top row, [5:3] middle row, [8:6] bottom row
//   thresh  in  4  effective popcount threshold (1..9)
//   result  out 1  1 when the match count reaches the threshold
module bnn_xnor_pe
  import bnn_conv_pkg::*;
(
  input  logic [WIN_BITS-1:0] weight,
  input  logic [WIN_BITS-1:0] window,
  input  logic [3:0]          thresh,
  output logic                result
);

  logic [WIN_BITS-1:0] match;
  logic [3:0]          count;

  always_comb begin
    match = ~(weight ^ window);
    count = '0;
    for (int i = 0; i < WIN_BITS; i++) begin
      count = count + {3'b000, match[i]};
    end
  end

  assign result = (count >= thresh);

endmodule

// File: rtl/bnn_conv_engine.sv
// Multi-filter binary 3x3 convolution engine.
// Loads up to MAX_FILTERS filters from the weight SRAM, then walks a stream of
// images in the input SRAM, writing one word per output row per filter to the
// output SRAM until a terminator (or invalid) header is found.
//   clk / reset_b             clock, asynchronous active-low reset
//   dut_run / dut_busy        start pulse (sampled in IDLE) / run in progress
//   dut_sram_read_address     input SRAM address, sram_dut_read_data one cycle later
//   dut_sram_write_*          output SRAM write port (registered)
//   dut_wmem_read_address     weight SRAM address, wmem_dut_read_data one cycle later
module bnn_conv_engine
  import bnn_conv_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int MAX_FILTERS = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data
);

  localparam int KW   = (MAX_FILTERS > 1) ? $clog2(MAX_FILTERS) : 1;
  localparam int PE_N = DATA_W - 2;

  state_t                state;
  logic [3:0]            fcnt;
  logic [WIN_BITS-1:0]   filt_w [MAX_FILTERS];
  logic [3:0]            filt_t [MAX_FILTERS];
  logic                  wreq, wvalid;
  logic [ADDR_W-1:0]     widx;
  logic                  rreq, rvalid;
  logic [ADDR_W-1:0]     base;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [HDR_DIM_W-1:0]  dim;
  logic [HDR_DIM_W-1:0]  out_row;
  logic [DATA_W-1:0]     row0, row1, row2, next_row;
  logic                  next_valid;
  logic [1:0]            fill_cnt;
  logic                  hdr_phase;
  logic [3:0]            k;

  // Weight-word decode
  logic [3:0] w_f_raw, w_f;
  assign w_f_raw = wmem_dut_read_data[3:0];
  assign w_f     = (w_f_raw > 4'(MAX_FILTERS)) ? 4'(MAX_FILTERS) : w_f_raw;

  // Header decode
  logic [HDR_DIM_W-1:0] hdr_dim;
  logic                 hdr_ok;
  assign hdr_dim = sram_dut_read_data[HDR_DIM_W-1:0];
  assign hdr_ok  = (sram_dut_read_data != DATA_W'(TERMINATOR)) &&
                   (hdr_dim >= HDR_DIM_W'(3)) && (int'(hdr_dim) <= DATA_W);

  // Output-row sequencing
  logic              last_k, last_row, incoming_ok, can_emit, more_rows;
  logic [DATA_W-1:0] incoming;
  assign last_k      = (k == (fcnt - 4'd1));
  assign last_row    = (out_row == (dim - HDR_DIM_W'(3)));
  // The next window row is either already captured or on the read bus now.
  assign incoming_ok = next_valid | rvalid;
  assign incoming    = next_valid ? next_row : sram_dut_read_data;
  // Shifting needs the next row; with one filter this can cost a bubble.
  assign can_emit    = !last_k || last_row || incoming_ok;
  assign more_rows   = (({1'b0, out_row} + 6'd4) < {1'b0, dim});

  // PE array, all columns share the selected filter
  logic [WIN_BITS-1:0] sel_w;
  logic [3:0]          sel_t;
  logic [PE_N-1:0]     pe_res, col_ok;
  logic [DATA_W-1:0]   out_word;
  assign sel_w = filt_w[k[KW-1:0]];
  assign sel_t = filt_t[k[KW-1:0]];

  generate
    for (genvar gi = 0; gi < PE_N; gi++) begin : g_pe
      bnn_xnor_pe u_pe (
        .weight (sel_w),
        .window ({row2[gi+2:gi], row1[gi+2:gi], row0[gi+2:gi]}),
        .thresh (sel_t),
        .result (pe_res[gi])
      );
      assign col_ok[gi] = ((gi + 2) < int'(dim));
    end
  endgenerate

  assign out_word = {2'b00, pe_res & col_ok};

  logic unused_wbits;
  assign unused_wbits = ^wmem_dut_read_data[DATA_W-1:THR_MSB+1];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                  <= ST_IDLE;
      dut_busy               <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      dut_wmem_read_address  <= '0;
      fcnt       <= '0;
      wreq       <= 1'b0;
      wvalid     <= 1'b0;
      widx       <= '0;
      rreq       <= 1'b0;
      rvalid     <= 1'b0;
      base       <= '0;
      wr_ptr     <= '0;
      dim        <= '0;
      out_row    <= '0;
      row0       <= '0;
      row1       <= '0;
      row2       <= '0;
      next_row   <= '0;
      next_valid <= 1'b0;
      fill_cnt   <= '0;
      hdr_phase  <= 1'b0;
      k          <= '0;
      for (int i = 0; i < MAX_FILTERS; i++) begin
        filt_w[i] <= '0;
        filt_t[i] <= '0;
      end
    end else begin
      dut_sram_write_enable <= 1'b0;
      rreq   <= 1'b0;
      rvalid <= rreq;
      wvalid <= wreq;
      widx   <= dut_wmem_read_address;

      case (state)
        ST_IDLE: begin
          if (dut_run) begin
            state                 <= ST_LOAD_W;
            dut_busy              <= 1'b1;
            dut_wmem_read_address <= '0;
            wreq                  <= 1'b1;
            dut_sram_read_address <= '0;
            base                  <= '0;
            wr_ptr                <= '0;
            hdr_phase             <= 1'b0;
            next_valid            <= 1'b0;
            k                     <= '0;
          end
        end

        // Addresses are issued speculatively every cycle; the returned word
        // is interpreted by the address it was read from (widx).
        ST_LOAD_W: begin
          dut_wmem_read_address <= dut_wmem_read_address + ADDR_W'(1);
          wreq                  <= 1'b1;
          if (wvalid) begin
            if (widx == '0) begin
              fcnt <= w_f;
              if (w_f == 4'd0) begin
                state    <= ST_DONE;
                dut_busy <= 1'b0;
                wreq     <= 1'b0;
              end
            end else if (widx <= ADDR_W'(fcnt)) begin
              filt_w[KW'(widx - ADDR_W'(1))] <= wmem_dut_read_data[WGT_MSB:WGT_LSB];
              filt_t[KW'(widx - ADDR_W'(1))] <= eff_thresh(wmem_dut_read_data[THR_MSB:THR_LSB]);
              if (widx == ADDR_W'(fcnt)) begin
                state <= ST_HDR;
                wreq  <= 1'b0;
              end
            end
          end
        end

        // Phase 0: header address on the bus, row 0 read issued behind it.
        // Phase 1: header data present; decode it.
        ST_HDR: begin
          if (!hdr_phase) begin
            dut_sram_read_address <= base + ADDR_W'(1);
            rreq                  <= 1'b1;
            hdr_phase             <= 1'b1;
          end else begin
            hdr_phase <= 1'b0;
            if (!hdr_ok) begin
              state    <= ST_DONE;
              dut_busy <= 1'b0;
            end else begin
              dim                   <= hdr_dim;
              dut_sram_read_address <= base + ADDR_W'(2);
              rreq                  <= 1'b1;
              fill_cnt              <= '0;
              state                 <= ST_FILL;
            end
          end
        end

        // Rows 0..2 arrive on consecutive cycles; row 3 is requested on the
        // way so it is in flight when OUT starts.
        ST_FILL: begin
          row0     <= row1;
          row1     <= row2;
          row2     <= sram_dut_read_data;
          fill_cnt <= fill_cnt + 2'd1;
          if (fill_cnt == 2'd0) begin
            dut_sram_read_address <= base + ADDR_W'(3);
            rreq                  <= 1'b1;
          end else if (fill_cnt == 2'd1) begin
            dut_sram_read_address <= base + ADDR_W'(4);
            rreq                  <= (dim > HDR_DIM_W'(3));
          end else begin
            state      <= ST_OUT;
            out_row    <= '0;
            k          <= '0;
            next_valid <= 1'b0;
          end
        end

        ST_OUT: begin
          if (rvalid) begin
            next_row   <= sram_dut_read_data;
            next_valid <= 1'b1;
          end
          if (can_emit) begin
            dut_sram_write_enable  <= 1'b1;
            dut_sram_write_data    <= out_word;
            dut_sram_write_address <= wr_ptr;
            wr_ptr                 <= wr_ptr + ADDR_W'(1);
            if (last_k) begin
              k <= '0;
              if (last_row) begin
                state                 <= ST_HDR;
                hdr_phase             <= 1'b0;
                base                  <= base + ADDR_W'(dim) + ADDR_W'(1);
                dut_sram_read_address <= base + ADDR_W'(dim) + ADDR_W'(1);
              end else begin
                row0       <= row1;
                row1       <= row2;
                row2       <= incoming;
                next_valid <= 1'b0;
                out_row    <= out_row + HDR_DIM_W'(1);
                if (more_rows) begin
                  dut_sram_read_address <= base + ADDR_W'(5) + ADDR_W'(out_row);
                  rreq                  <= 1'b1;
                end
              end
            end else begin
              k <= k + 4'd1;
            end
          end
        end

        ST_DONE: begin
          dut_busy <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          dut_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bnn_conv_engine.md
# bnn_conv_engine

Multi-filter binary (XNOR/popcount) 3x3 convolution engine sitting between the input/output SRAM and the weight SRAM. It generalises the single-filter fixed-size convolver to:
- any image dimension N from 3 to DATA_W;
- up to MAX_FILTERS filters per run;
- a per-filter programmable popcount threshold.

It processes a stream of images until it reads a terminator header, writing one output word per output row per filter.

## Interface
Parameters:
- DATA_W, 16: SRAM word width and maximum image dimension.
- ADDR_W, 12: width of all SRAM addresses.
- MAX_FILTERS, 8: number of filter weight registers; power of two, maximum 15.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset_b  in  1  asynchronous, active-low reset.
- dut_run  in  1  start pulse; sampled only in IDLE.
- dut_busy  out  reg 1  high from the first cycle after dut_run is accepted until the run completes.
- dut_sram_read_address  out  reg ADDR_W  input SRAM read address.
- sram_dut_read_data  in  DATA_W  input SRAM data; valid one cycle after the address.
- dut_sram_write_address  out  reg ADDR_W  output SRAM write address.
- dut_sram_write_data  out  reg DATA_W  output SRAM write data.
- dut_sram_write_enable  out  reg 1  write strobe; one word per cycle.
- dut_wmem_read_address  out  reg ADDR_W  weight SRAM read address.
- wmem_dut_read_data  in  DATA_W  weight SRAM data; one-cycle latency.

Reset value of every output: 0.

## Operation
Weight memory layout:
- Address 0, bits [3:0]: filter count F.
- Address 1..F: one word per filter.
  - Bits [8:0]: weights. Bits 0-2 are the top row (columns c..c+2), bits 3-5 the middle row, bits 6-8 the bottom row.
  - Bits [12:9]: threshold T. T=0 or T>9 means T=5.
- F > MAX_FILTERS is clamped to MAX_FILTERS.

Input SRAM layout:
- Images are packed from address 0.
- Each image is a header word followed by N row words. Header bits [4:0] = N.
- Row word bit j is pixel column j. Bits ≥ N are ignored.
- Header 16'h00FF terminates the run.
- Any header with N < 3 or N > DATA_W also terminates the run. No writes are issued for it.

Output computation:
- Bit c of the output for row r, filter k = 1 iff popcount(~(w_k ^ window(r,c))) ≥ T_k, for c in 0..N-3.
- Output bits N-2..DATA_W-1 are 0.

Output order and addressing:
- For each output row r = 0..N-3, write F consecutive words (filter 0 first).
- Write address starts at 0 for each run and increments by 1 per write across all images. It is not reset between images.
- Address wraps modulo 2^ADDR_W.

FSM (one-hot, states IDLE, LOAD_W, HDR, FILL, OUT, DONE):
- IDLE -> LOAD_W on dut_run.
- LOAD_W reads addresses 0..F. F=0 -> DONE.
- HDR reads the header. Terminator or invalid header -> DONE; otherwise -> FILL.
- FILL loads the first 3 rows into the row0/row1/row2 shift window -> OUT.
- OUT emits F words for the current row. It prefetches the next row during emission and shifts the window after the F-th write. After row N-3 -> HDR at the next image address (header + N + 1).
- DONE deasserts dut_busy -> IDLE.

Reset mid-run: returns to IDLE immediately with all outputs 0. The next dut_run starts a fresh run.

## Timing
- dut_busy rises the cycle after dut_run is sampled in IDLE. dut_run is ignored while dut_busy=1.
- dut_sram_write_enable is registered; data and address are valid in the same cycle as enable.
- In OUT, writes are back-to-back, with no gap between rows of the same image when F ≥ 2. A one-cycle bubble between rows is allowed when F=1.
- Image-to-image overhead (HDR+FILL) is at most 6 cycles.
- The first write occurs no later than F+10 cycles after dut_run.
- dut_busy falls the cycle after the terminator header is decoded, and never before the final write has completed.
- Filter weights are loaded once per run. They hold between images and are cleared by reset.

## Structure
Package bnn_conv_pkg holds:
- the state encoding;
- TERMINATOR = 16'h00FF and DEFAULT_THRESH = 5;
- weight-field bit positions (WGT_LSB/MSB, THR_LSB/MSB);
- the header dimension field width.

Sub-module bnn_xnor_pe:
- Inputs: 9-bit weight, 9-bit window, 4-bit threshold.
- Output: 1-bit result.
- Instantiated DATA_W-2 times, sharing the currently selected filter's weight and threshold (the filter is selected by filter index k).

## Test plan
- F=1, w=9'h1FF, T=5, one 10x10 all-ones image then terminator -> 8 writes of 16'h00FF at addresses 0..7, then dut_busy falls.
- F=2 (w0=9'h1FF T=9, w1=9'h000 T=9), one 3x3 image of rows 3'b111 -> address 0 = 16'h0001, address 1 = 16'h0000.
- Images N=16 then N=12, F=1 -> writes at addresses 0..13 then 14..23, with no extra header writes; word 14 has bits 15:10 = 0.
- Header 16'h0002 at address 0 -> zero writes, dut_busy high for at most 6 cycles.
- Assert reset_b low during OUT, then rerun -> output addresses restart at 0 and results match a clean run.
- F=0 in weight address 0 -> no writes; dut_run pulsed while busy is ignored.
